clk_div_sched: RTL
==================

# clk_div_sched

Runtime-programmable clock-enable scheduler. It derives a divided clock (`div_clk`) and a one-cycle period tick (`div_tick`) from the single system clock. The divisor is reconfigured through a valid/ready handshake, and a new divisor only takes effect on a period boundary, so no output phase is ever truncated. It sits between the system clock source and slow-rate consumers (sampling strobes, LED/UART timing), replacing free-running `#delay` clock models with synthesizable sequencing.

## Interface
Parameters:
- `DIV_WIDTH`, 8: width of the divisor and period counter.
- `DEFAULT_DIV`, 4: divisor loaded at reset. Values below 2 are clamped to 2.
- `MEAS_WIDTH`, 16: width of the measured-period output.

Ports:
- `clk` input 1: the single system clock. All logic is on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: run request, sampled every cycle.
- `cfg_valid` input 1: a new divisor is offered.
- `cfg_div` input DIV_WIDTH: the offered divisor.
- `cfg_ready` output 1: the block can accept a divisor.
- `div_clk` output 1: registered divided clock.
- `div_tick` output 1: one-`clk` pulse on each `div_clk` rising phase start.
- `busy` output 1: the block is in RUN or STOPPING.
- `meas_period` output MEAS_WIDTH: last measured tick-to-tick distance in `clk` cycles.
- `meas_valid` output 1: one-cycle strobe when `meas_period` updates.

## Operation
- Handshake: a divisor transfers when `cfg_valid && cfg_ready`. An accepted value below 2 is stored as 2.
- Registers:
  - `div_cur` is the divisor currently in use.
  - `div_pend` holds an accepted divisor that has not yet been applied, flagged by `pend_v`.
  - `cnt` runs from 0 to `div_cur-1`.
- `cfg_ready` is `!pend_v`. At most one update can be outstanding.
- State IDLE:
  - `cnt` = 0, `div_clk` = 0, `div_tick` = 0.
  - A divisor accepted in IDLE loads `div_cur` directly. `pend_v` is never set in IDLE.
  - `en` = 1 moves the block to RUN.
- State RUN:
  - `cnt` increments and wraps to 0 after reaching `div_cur-1`.
  - `div_clk` = 1 while `cnt < ceil(div_cur/2)`, else 0. Duty is 50% for even divisors; for odd divisors the high phase is one cycle longer.
  - `div_tick` = 1 when `cnt` == 0.
- Wrap cycle (RUN, `cnt == div_cur-1`):
  - If `pend_v`, then `div_cur <= div_pend` and `pend_v` clears.
  - A divisor accepted on this same cycle bypasses `div_pend` and applies to the period that starts next.
  - If `en` = 0 on this cycle, the block goes to IDLE instead of starting a new period.
- `en` = 0 sampled in RUN before the wrap cycle moves the block to STOPPING.
- State STOPPING:
  - Behaves like RUN, but goes to IDLE at the wrap cycle.
  - `en` = 1 during STOPPING returns the block to RUN; the period stays continuous.
- Reset mid-operation: every register returns to its reset value on the next edge. The pending divisor is discarded.

## Timing
- Reset values:
  - `div_clk` = 0, `div_tick` = 0, `busy` = 0.
  - `cfg_ready` = 1.
  - `meas_period` = 0, `meas_valid` = 0.
  - `div_cur` = `max(DEFAULT_DIV,2)`, `pend_v` = 0, state IDLE.
- Start latency: `en` sampled high in IDLE at edge t gives `div_clk` = 1, `div_tick` = 1 and `busy` = 1 at t+1.
- Stop: `div_clk` falls only at the natural phase boundary. It stays 0 from the first cycle after the wrap cycle. No runt pulses.
- Divisor change in RUN: the first period using the new divisor starts on the cycle after the wrap. `cfg_ready` stays low from acceptance until that cycle.
- Tick spacing in steady state is exactly `div_cur` cycles.

## Configuration
- Macro `CLK_DIV_SCHED_MEAS_EN`.
- Defined:
  - A free-running counter measures `clk` cycles between consecutive `div_tick`s.
  - On every tick except the first after leaving IDLE, the count is written to `meas_period` and `meas_valid` pulses in the same cycle as `div_tick`.
  - The counter saturates at all-ones.
- Undefined: `meas_period` and `meas_valid` are tied to 0 and the measurement logic is absent.

## Test plan
- Reset, then `en` = 1 with `DEFAULT_DIV` = 4 -> `div_clk` pattern 1,1,0,0 repeating, `div_tick` every 4 cycles, first tick one cycle after `en`.
- IDLE, write `cfg_div` = 5, then `en` = 1 -> high 3 cycles, low 2 cycles, `cfg_ready` stays 1.
- RUN with div 4, write `cfg_div` = 6 at `cnt` = 1 -> `cfg_ready` low until the wrap, current period finishes with 4 cycles, next tick gap is 6.
- Write `cfg_div` = 0 -> behaves as div 2 (1,0 pattern); write `cfg_div` = 1 -> also div 2.
- Drop `en` at `cnt` = 0 with div 8 -> `div_clk` completes 4 high and 4 low cycles, then IDLE with `busy` = 0; re-raise `en` during STOPPING -> no gap in ticks.
- With `CLK_DIV_SCHED_MEAS_EN` defined, div 10 -> `meas_valid` from the second tick onward with `meas_period` = 10; assert `rst` mid-period -> all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/clk_div_sched_if.sv
// -----------------------------------------------------------------------------
// clk_div_sched_if
//
// Divisor reconfiguration channel for clk_div_sched. It is a plain valid/ready
// handshake: a divisor transfers on any rising clk edge where both cfg_valid
// and cfg_ready are high.
//
// Parameters:
//   DIV_WIDTH  width of the offered divisor; must match the scheduler's
//              DIV_WIDTH.
//
// Signals:
//   cfg_valid  producer -> scheduler  a new divisor is offered
//   cfg_div    producer -> scheduler  the offered divisor
//   cfg_ready  scheduler -> producer  the scheduler can accept a divisor
//
// Modports:
//   master     the side that offers divisors (CPU, register block, bench)
//   slave      the scheduler itself
// -----------------------------------------------------------------------------
interface clk_div_sched_if #(
  parameter int DIV_WIDTH = 8
) ();

  logic                 cfg_valid;
  logic [DIV_WIDTH-1:0] cfg_div;
  logic                 cfg_ready;

  modport master (
    output cfg_valid,
    output cfg_div,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    output cfg_ready
  );

endinterface : clk_div_sched_if

// File: rtl/clk_div_sched.sv
// -----------------------------------------------------------------------------
// clk_div_sched
//
// Runtime-programmable clock-enable scheduler. It derives a registered divided
// clock (div_clk) and a one-cycle period tick (div_tick) from the system
// clock. A new divisor can be offered at any time over the cfg handshake, but
// it only takes effect on a period boundary, so no div_clk phase is ever
// truncated. Stopping is also deferred to the period boundary, so div_clk
// never produces a runt pulse.
//
// Parameters:
//   DIV_WIDTH    width of the divisor and period counter
//   DEFAULT_DIV  divisor loaded at reset (values below 2 are clamped to 2)
//   MEAS_WIDTH   width of the measured-period output
//
// Ports:
//   clk          system clock; all logic is on its rising edge
//   rst          synchronous, active-high reset
//   en           run request, sampled every cycle
//   cfg          divisor handshake (slave side): cfg_valid / cfg_div / cfg_ready
//   div_clk      registered divided clock (high phase first, ceil(div/2) long)
//   div_tick     one-clk pulse at the start of every div_clk period
//   busy         high while a period is in progress (RUN or STOPPING)
//   meas_period  last measured tick-to-tick distance in clk cycles
//   meas_valid   one-cycle strobe, coincident with div_tick, when meas_period
//                updates
//
// Build option:
//   CLK_DIV_SCHED_MEAS_EN  when defined, adds a saturating free-running
//                          counter that measures the distance between
//                          consecutive ticks. When undefined, meas_period and
//                          meas_valid are tied to 0 and no measurement logic
//                          exists.
// -----------------------------------------------------------------------------
module clk_div_sched #(
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 4,
  parameter int MEAS_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  clk_div_sched_if.slave        cfg,
  output logic                  div_clk,
  output logic                  div_tick,
  output logic                  busy,
  output logic [MEAS_WIDTH-1:0] meas_period,
  output logic                  meas_valid
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [DIV_WIDTH-1:0] MIN_DIV = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH:0]   ONE_X   = (DIV_WIDTH + 1)'(1);

  // Reset divisor, clamped so that a period always has a high and a low phase.
  localparam logic [DIV_WIDTH-1:0] RST_DIV =
    (DEFAULT_DIV < 2) ? MIN_DIV : DIV_WIDTH'(DEFAULT_DIV);

  // IDLE:     no period in progress, outputs low, divisor writes apply at once.
  // RUN:      periods repeat back to back while en stays high.
  // STOPPING: en was dropped mid-period; the period is completed first.
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_STOPPING = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t               r_state;
  logic [DIV_WIDTH-1:0] r_cnt;       // position inside the current period
  logic [DIV_WIDTH-1:0] r_div_cur;   // divisor of the current period
  logic [DIV_WIDTH-1:0] r_div_pend;  // accepted divisor waiting for the wrap
  logic                 r_pend_v;    // r_div_pend holds a value
  logic                 r_div_clk;
  logic                 r_div_tick;
  logic                 r_busy;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic                 w_accept;
  logic [DIV_WIDTH-1:0] w_cfg_div_clamped;
  logic                 w_in_period;
  logic                 w_wrap;
  logic [DIV_WIDTH-1:0] w_cnt_inc;
  logic [DIV_WIDTH:0]   w_high_len;
  logic                 w_clk_at_inc;
  logic [DIV_WIDTH-1:0] w_div_next;

  // Only one update may be outstanding, so readiness is simply "no pending".
  assign cfg.cfg_ready = !r_pend_v;
  assign w_accept      = cfg.cfg_valid && !r_pend_v;

  assign w_cfg_div_clamped = (cfg.cfg_div < MIN_DIV) ? MIN_DIV : cfg.cfg_div;

  assign w_in_period = (r_state != S_IDLE);
  assign w_wrap      = w_in_period && (r_cnt == (r_div_cur - ONE));
  assign w_cnt_inc   = r_cnt + ONE;

  // High phase length is ceil(div/2); one extra bit keeps div = 2^W-1 exact.
  assign w_high_len   = ({1'b0, r_div_cur} + ONE_X) >> 1;
  assign w_clk_at_inc = ({1'b0, w_cnt_inc} < w_high_len);

  // Divisor for the period starting after a wrap. A divisor accepted on the
  // wrap cycle itself skips r_div_pend; it can only be accepted when nothing
  // is pending, so the two sources never compete.
  assign w_div_next = w_accept ? w_cfg_div_clamped :
                      r_pend_v ? r_div_pend        :
                                 r_div_cur;

  // ---------------------------------------------------------------------------
  // Scheduler FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: every register here is written with <= so all of them update from
  // the same pre-edge values; mixing in = would make results depend on
  // statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: r_div_pend is a data register guarded by r_pend_v and would be
      // safe to leave unreset; it is cleared anyway so a discarded divisor can
      // never be observed after reset.
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_div_cur  <= RST_DIV;
      r_div_pend <= '0;
      r_pend_v   <= 1'b0;
      r_div_clk  <= 1'b0;
      r_div_tick <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          // No period is running, so a new divisor can be applied directly.
          if (w_accept) begin
            r_div_cur <= w_cfg_div_clamped;
          end
          if (en) begin
            // cnt = 0 is always inside the high phase, so the first cycle of
            // the first period is high and carries the tick.
            r_state    <= S_RUN;
            r_div_clk  <= 1'b1;
            r_div_tick <= 1'b1;
            r_busy     <= 1'b1;
          end else begin
            r_div_clk  <= 1'b0;
            r_div_tick <= 1'b0;
            r_busy     <= 1'b0;
          end
        end

        S_RUN, S_STOPPING: begin
          if (w_wrap) begin
            r_cnt      <= '0;
            r_div_cur  <= w_div_next;
            r_pend_v   <= 1'b0;
            // RUN and STOPPING only differ in intent; the decision to start
            // another period is taken from en on the wrap cycle alone.
            if (en) begin
              r_state    <= S_RUN;
              r_div_clk  <= 1'b1;
              r_div_tick <= 1'b1;
              r_busy     <= 1'b1;
            end else begin
              r_state    <= S_IDLE;
              r_div_clk  <= 1'b0;
              r_div_tick <= 1'b0;
              r_busy     <= 1'b0;
            end
          end else begin
            r_cnt      <= w_cnt_inc;
            r_div_clk  <= w_clk_at_inc;
            r_div_tick <= 1'b0;
            r_busy     <= 1'b1;
            // Mid-period writes are parked until the wrap.
            if (w_accept) begin
              r_div_pend <= w_cfg_div_clamped;
              r_pend_v   <= 1'b1;
            end
            r_state <= en ? S_RUN : S_STOPPING;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign div_clk  = r_div_clk;
  assign div_tick = r_div_tick;
  assign busy     = r_busy;

  // ---------------------------------------------------------------------------
  // Optional tick-to-tick period measurement
  // ---------------------------------------------------------------------------
`ifdef CLK_DIV_SCHED_MEAS_EN
  localparam logic [MEAS_WIDTH-1:0] MEAS_ONE = MEAS_WIDTH'(1);

  logic                  w_start;      // tick that leaves IDLE
  logic                  w_restart;    // tick that continues a run
  logic [MEAS_WIDTH-1:0] w_gap_next;
  logic [MEAS_WIDTH-1:0] r_gap;        // cycles since the last tick
  logic [MEAS_WIDTH-1:0] r_meas_period;
  logic                  r_meas_valid;

  assign w_start   = (r_state == S_IDLE) && en;
  assign w_restart = w_wrap && en;

  // Saturate instead of wrapping so a very long gap reads as all-ones.
  assign w_gap_next = (&r_gap) ? r_gap : (r_gap + MEAS_ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gap         <= '0;
      r_meas_period <= '0;
      r_meas_valid  <= 1'b0;
    end else begin
      r_meas_valid <= 1'b0;
      if (w_start || w_restart) begin
        r_gap <= '0;
        // The first tick after IDLE has no predecessor in this run, so only
        // continuing ticks produce a measurement.
        if (w_restart) begin
          r_meas_period <= w_gap_next;
          r_meas_valid  <= 1'b1;
        end
      end else begin
        r_gap <= w_gap_next;
      end
    end
  end

  assign meas_period = r_meas_period;
  assign meas_valid  = r_meas_valid;
`else
  assign meas_period = '0;
  assign meas_valid  = 1'b0;
`endif

endmodule : clk_div_sched
